uart_rx_fsm: RTL and testbench

//  Oversampling UART receiver; direct downstream peer of uart_tx_moore (consumes its serial_out).

---
 rtl/uart_rx_fsm.sv | 191 +++++++++++++++++++
 tb/tb_uart_rx_fsm.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fsm.sv
// -----------------------------------------------------------------------------
// uart_rx_fsm
//   Oversampling 8N1 UART receiver with optional parity. It accepts the serial
//   stream produced by uart_tx_moore. A received byte appears on bus_out
//   together with a 1-cycle data_valid strobe. A low stop bit raises a
//   frame_err pulse, and a parity mismatch raises a parity_err pulse. The FSM
//   is Moore style and every output is registered.
//
// Parameters
//   OVERSAMPLE  clk_baud cycles per bit (even, >= 4)
//   PARITY      0 = none, 1 = even, 2 = odd
//
// Ports
//   clk_baud    in   sampling clock, OVERSAMPLE x baud rate (the only clock)
//   rst         in   asynchronous, active-high reset
//   serial_in   in   UART line, idle high, LSB first, asynchronous to clk_baud
//   bus_out     out  [7:0] last good received byte
//   data_valid  out  1-cycle pulse: bus_out just updated with a good frame
//   frame_err   out  1-cycle pulse: stop bit sampled low
//   parity_err  out  1-cycle pulse: parity mismatch with a good stop bit
//   busy        out  high whenever the FSM is not in IDLE
// -----------------------------------------------------------------------------
module uart_rx_fsm #(
  parameter int OVERSAMPLE = 16,
  parameter int PARITY     = 0
) (
  input  logic       clk_baud,
  input  logic       rst,
  input  logic       serial_in,
  output logic [7:0] bus_out,
  output logic       data_valid,
  output logic       frame_err,
  output logic       parity_err,
  output logic       busy
);

  localparam int CW = $clog2(OVERSAMPLE);

  // The START state samples at the middle of the start bit. From then on, a
  // full bit period lands every later sample near the middle of its bit.
  localparam logic [CW-1:0] CNT_MID = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] CNT_END = CW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PAR,
    S_STOP,
    S_BREAK
  } state_t;

  state_t          state;
  logic            sync1;
  logic            rxs;
  logic [CW-1:0]   cnt;
  logic [2:0]      bitn;
  logic [7:0]      shift_reg;
  logic            par_bit;
  logic            par_ok;

  // Two-flop synchronizer. Both stages reset to the idle line level, so a
  // reset release never looks like a start bit.
  // NOTE: sequential state is always written with <= so every flop samples
  // the pre-edge value of every other flop, whatever the statement order.
  always_ff @(posedge clk_baud or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b1;
      rxs   <= 1'b1;
    end else begin
      sync1 <= serial_in;
      rxs   <= sync1;
    end
  end

  // Even parity requires XOR over data and parity bit to be 0. Odd parity
  // requires 1. With no parity the check always passes, so parity_err stays 0.
  assign par_ok = (PARITY == 0) || ((^{shift_reg, par_bit}) == (PARITY == 2));

  always_ff @(posedge clk_baud or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      bitn       <= '0;
      // NOTE: the shift register is reset along with the control flops. It is
      // only 8 bits, and resetting it keeps the datapath free of X values.
      shift_reg  <= '0;
      par_bit    <= 1'b0;
      bus_out    <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      busy       <= 1'b0;
    end else begin
      // Status strobes default low, so each one is high for exactly one cycle.
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;

      case (state)
        S_IDLE: begin
          if (!rxs) begin
            state <= S_START;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end

        S_START: begin
          if (cnt == CNT_MID) begin
            cnt <= '0;
            if (!rxs) begin
              state <= S_DATA;
              bitn  <= '0;
            end else begin
              // The line went back high before mid start bit, so the low level
              // was a glitch. Drop it without any pulse.
              state <= S_IDLE;
              busy  <= 1'b0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        S_DATA: begin
          if (cnt == CNT_END) begin
            cnt       <= '0;
            shift_reg <= {rxs, shift_reg[7:1]};
            if (bitn == 3'd7) begin
              bitn  <= '0;
              state <= (PARITY != 0) ? S_PAR : S_STOP;
            end else begin
              bitn <= bitn + 3'd1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        S_PAR: begin
          if (cnt == CNT_END) begin
            cnt     <= '0;
            par_bit <= rxs;
            state   <= S_STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        S_STOP: begin
          if (cnt == CNT_END) begin
            cnt <= '0;
            if (rxs) begin
              // The FSM returns to IDLE at mid stop bit. That leaves half a bit
              // of margin to catch a back-to-back start edge.
              state <= S_IDLE;
              busy  <= 1'b0;
              if (par_ok) begin
                bus_out    <= shift_reg;
                data_valid <= 1'b1;
              end else begin
                parity_err <= 1'b1;
              end
            end else begin
              frame_err <= 1'b1;
              state     <= S_BREAK;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        S_BREAK: begin
          // Stay here until the line goes high, so a held-low line (break)
          // does not start a new frame.
          if (rxs) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end

        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_fsm.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_fsm
//   Directed bench for uart_rx_fsm. It uses two instances: dut0 (no parity)
//   and dut1 (even parity), both at OVERSAMPLE=16. The sender pushes an
//   expected event (kind, bus_out, cycle) for each frame. A per-DUT monitor
//   pops an event on every output pulse and compares it.
// -----------------------------------------------------------------------------
module tb_uart_rx_fsm;

  localparam int OS = 16;

  typedef struct {
    logic [2:0] code;  // {data_valid, frame_err, parity_err}
    logic [7:0] bus;
    int         cyc;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx0, rx1;
  logic [7:0] bus0, bus1;
  logic       dv0, fe0, pe0, busy0;
  logic       dv1, fe1, pe1, busy1;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  ev_t  q0[$];
  ev_t  q1[$];
  logic [7:0] exp_bus0, exp_bus1;

  uart_rx_fsm #(.OVERSAMPLE(OS), .PARITY(0)) dut0 (
    .clk_baud  (clk),
    .rst       (rst),
    .serial_in (rx0),
    .bus_out   (bus0),
    .data_valid(dv0),
    .frame_err (fe0),
    .parity_err(pe0),
    .busy      (busy0)
  );

  uart_rx_fsm #(.OVERSAMPLE(OS), .PARITY(1)) dut1 (
    .clk_baud  (clk),
    .rst       (rst),
    .serial_in (rx1),
    .bus_out   (bus1),
    .data_valid(dv1),
    .frame_err (fe1),
    .parity_err(pe1),
    .busy      (busy1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic drive(input int id, input logic v);
    if (id == 0) rx0 = v;
    else         rx1 = v;
  endtask

  // Send one frame starting at the current negedge. The stop bit level and
  // its length are chosen by the caller. Back-to-back calls produce frames
  // with no gap between them.
  task automatic send(input int id, input logic [7:0] d, input logic par_val,
                      input logic stop_val, input int stop_cycles);
    ev_t e;
    logic [7:0] cur;
    cur   = (id == 0) ? exp_bus0 : exp_bus1;
    // Edge 0 is the next posedge (cyc+1), and the pulse follows edge 154 (+16 with parity).
    e.cyc = cyc + 155 + ((id == 1) ? OS : 0);
    if (!stop_val) begin
      e.code = 3'b010;
      e.bus  = cur;
    end else if (id == 1 && (par_val != ^d)) begin
      e.code = 3'b001;
      e.bus  = cur;
    end else begin
      e.code = 3'b100;
      e.bus  = d;
      cur    = d;
    end
    if (id == 0) begin
      exp_bus0 = cur;
      q0.push_back(e);
    end else begin
      exp_bus1 = cur;
      q1.push_back(e);
    end
    drive(id, 1'b0);
    repeat (OS) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      drive(id, d[i]);
      repeat (OS) @(negedge clk);
    end
    if (id == 1) begin
      drive(id, par_val);
      repeat (OS) @(negedge clk);
    end
    drive(id, stop_val);
    repeat (stop_cycles) @(negedge clk);
    drive(id, 1'b1);
  endtask

  task automatic mon(input int id, input logic dv, input logic fe, input logic pe,
                     input logic [7:0] bus);
    ev_t e;
    logic empty;
    if (dv | fe | pe) begin
      check("pulse_onehot", $countones({dv, fe, pe}), 1);
      empty = (id == 0) ? (q0.size() == 0) : (q1.size() == 0);
      if (empty) begin
        check($sformatf("unexpected_pulse_dut%0d", id), {29'd0, dv, fe, pe}, 0);
      end else begin
        if (id == 0) e = q0.pop_front();
        else         e = q1.pop_front();
        check($sformatf("pulse_kind_dut%0d", id), {29'd0, dv, fe, pe}, {29'd0, e.code});
        check($sformatf("bus_out_dut%0d", id), bus, e.bus);
        check($sformatf("pulse_cycle_dut%0d", id), cyc, e.cyc);
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      mon(0, dv0, fe0, pe0, bus0);
      mon(1, dv1, fe1, pe1, bus1);
    end
  end

  initial begin
    rst = 1'b1;
    rx0 = 1'b1;
    rx1 = 1'b1;
    exp_bus0 = '0;
    exp_bus1 = '0;

    // T1: reset held while the line toggles
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      rx0 = ~rx0;
      rx1 = ~rx1;
    end
    check("reset_outputs_dut0", {bus0, dv0, fe0, pe0, busy0}, 0);
    check("reset_outputs_dut1", {bus1, dv1, fe1, pe1, busy1}, 0);
    rx0 = 1'b1;
    rx1 = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("idle_after_reset", {busy0, busy1}, 0);

    // T2: single frame 0x99 with a pulse expected at edge 154
    send(0, 8'h99, 1'b0, 1'b1, OS);
    repeat (20) @(negedge clk);
    check("t2_bus_hold", bus0, 8'h99);

    // T3: back-to-back frames with one stop bit each
    send(0, 8'h62, 1'b0, 1'b1, OS);
    send(0, 8'h99, 1'b0, 1'b1, OS);
    repeat (20) @(negedge clk);

    // T4: 4-cycle low glitch on the idle line
    rx0 = 1'b0;
    repeat (4) @(negedge clk);
    rx0 = 1'b1;
    repeat (2) @(negedge clk);
    check("glitch_busy_high", busy0, 1);
    repeat (20) @(negedge clk);
    check("glitch_busy_low", busy0, 0);
    check("glitch_bus_hold", bus0, 8'h99);

    // T5: stop bit held low for 30 cycles, then a good frame
    send(0, 8'h55, 1'b0, 1'b0, 30);
    check("break_busy_held", busy0, 1);
    repeat (5) @(negedge clk);
    check("break_released", busy0, 0);
    send(0, 8'hA5, 1'b0, 1'b1, OS);
    repeat (20) @(negedge clk);

    // Reset asserted mid-DATA: the frame is aborted silently
    rx0 = 1'b0;
    repeat (3 * OS) @(negedge clk);
    check("mid_data_busy", busy0, 1);
    #1 rst = 1'b1;
    #1;
    check("async_reset_dut0", {bus0, dv0, fe0, pe0, busy0}, 0);
    exp_bus0 = '0;
    exp_bus1 = '0;
    rx0 = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (200) @(negedge clk);
    check("after_abort_idle", {bus0, busy0}, 0);
    send(0, 8'hC3, 1'b0, 1'b1, OS);
    repeat (20) @(negedge clk);

    // T6: even parity on dut1
    send(1, 8'h3C, 1'b0, 1'b1, OS);
    send(1, 8'h07, 1'b0, 1'b1, OS);
    send(1, 8'h07, 1'b1, 1'b1, OS);
    repeat (20) @(negedge clk);
    check("parity_final_bus", bus1, 8'h07);

    repeat (50) @(negedge clk);
    check("scoreboard_drained_dut0", q0.size(), 0);
    check("scoreboard_drained_dut1", q1.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
